// File: rtl/pwm_fader_multi.sv
// pwm_fader_multi: multi-channel LED PWM with off/static/breathe/blink modes; FADE_STAGGER_EN staggers breathe start phases
module pwm_fader_multi #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int PWM_FREQUENCY  = 1_000,
  parameter int STEP_FREQUENCY = 500,
  parameter int CHANNELS       = 3,
  parameter int WIDTH          = 8,
  parameter int BLINK_STEPS    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [WIDTH*CHANNELS-1:0] level,
  input  logic [WIDTH-1:0]          minDuty,
  input  logic [WIDTH-1:0]          maxDuty,
  output logic [WIDTH*CHANNELS-1:0] duty,
  output logic                      periodStart,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       nOut
);
  localparam int MAXI = (1 << WIDTH) - 1;
  localparam int PWM_RAW = CLK_FREQ / (PWM_FREQUENCY * MAXI);
  localparam int STEP_RAW = CLK_FREQ / STEP_FREQUENCY;
  localparam int PWM_DIV = PWM_RAW > 1 ? PWM_RAW : 1;
  localparam int STEP_DIV = STEP_RAW > 1 ? STEP_RAW : 1;
  localparam int PW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam int BW = BLINK_STEPS > 1 ? $clog2(BLINK_STEPS) : 1;
`ifdef FADE_STAGGER_EN
  localparam int STAGGER = 1;
`else
  localparam int STAGGER = 0;
`endif
  logic [CHANNELS-1:0][1:0] md, mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0] lvl, phase_q, phase_d, duty_q, duty_d, init_p;
  logic [CHANNELS-1:0][BW-1:0] bcnt_q, bcnt_d;
  logic [CHANNELS-1:0] up_q, up_d, bon_q, bon_d, entry, out_q, out_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] spre_q, spre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic pwm_tick, step_tick, wrap, ps_q, ps_d;
  assign md = mode;
  assign lvl = level;
  assign duty = duty_q;
  assign periodStart = ps_q;
  assign out = out_q;
  assign nOut = ~out_q;
  function automatic logic [WIDTH-1:0] start_phase(int i);
    return WIDTH'(STAGGER * i * MAXI / CHANNELS);
  endfunction
  function automatic logic [WIDTH-1:0] clamp(logic [WIDTH-1:0] p, logic [WIDTH-1:0] lo, logic [WIDTH-1:0] hi);
    return p < lo ? lo : p > hi ? hi : p;
  endfunction
  always_comb begin
    pwm_tick = enable && pre_q == PW'(PWM_DIV - 1);
    step_tick = enable && spre_q == SW'(STEP_DIV - 1);
    wrap = pwm_tick && cnt_q == WIDTH'(MAXI - 1);
    pre_d = !enable ? pre_q : pwm_tick ? '0 : pre_q + 1'b1;
    spre_d = !enable ? spre_q : step_tick ? '0 : spre_q + 1'b1;
    cnt_d = !pwm_tick ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    ps_d = wrap;
    mode_d = enable ? md : mode_q;
    for (int i = 0; i < CHANNELS; i++) begin
      // entry into breathe/blink (mode bit 1 set) restarts the channel; it outranks a coincident step
      entry[i] = enable && md[i] != mode_q[i] && md[i][1];
      init_p[i] = clamp(start_phase(i), minDuty, maxDuty);
      phase_d[i] = phase_q[i];
      up_d[i] = up_q[i];
      bcnt_d[i] = bcnt_q[i];
      bon_d[i] = bon_q[i];
      if (entry[i]) begin
        phase_d[i] = init_p[i];
        up_d[i] = 1'b1;
        bcnt_d[i] = '0;
        bon_d[i] = 1'b1;
      end else if (step_tick && md[i] == 2'b10) begin
        if (minDuty >= maxDuty) phase_d[i] = minDuty;
        else if (phase_q[i] < minDuty || phase_q[i] > maxDuty) phase_d[i] = clamp(phase_q[i], minDuty, maxDuty);
        else if (up_q[i]) begin
          up_d[i] = phase_q[i] < maxDuty;
          phase_d[i] = phase_q[i] < maxDuty ? phase_q[i] + 1'b1 : phase_q[i] - 1'b1;
        end else begin
          up_d[i] = phase_q[i] <= minDuty;
          phase_d[i] = phase_q[i] > minDuty ? phase_q[i] - 1'b1 : phase_q[i] + 1'b1;
        end
      end else if (step_tick && md[i] == 2'b11) begin
        bcnt_d[i] = bcnt_q[i] == BW'(BLINK_STEPS - 1) ? '0 : bcnt_q[i] + 1'b1;
        bon_d[i] = bcnt_q[i] == BW'(BLINK_STEPS - 1) ? ~bon_q[i] : bon_q[i];
      end
      duty_d[i] = !wrap ? duty_q[i] :
                  md[i] == 2'b01 ? lvl[i] :
                  md[i] == 2'b10 ? (entry[i] ? init_p[i] : phase_q[i]) :
                  md[i] == 2'b11 && (entry[i] || bon_q[i]) ? lvl[i] : '0;
      out_d[i] = enable && cnt_q < duty_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      spre_q <= '0;
      cnt_q <= '0;
      ps_q <= 1'b0;
      mode_q <= '0;
      duty_q <= '0;
      out_q <= '0;
      up_q <= '1;
      bon_q <= '1;
      bcnt_q <= '0;
      for (int i = 0; i < CHANNELS; i++) phase_q[i] <= start_phase(i);
    end else begin
      pre_q <= pre_d;
      spre_q <= spre_d;
      cnt_q <= cnt_d;
      ps_q <= ps_d;
      mode_q <= mode_d;
      duty_q <= duty_d;
      out_q <= out_d;
      up_q <= up_d;
      bon_q <= bon_d;
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
    end
  end
endmodule
